// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - shared DNN datapath defaults, neuron FSM states and saturation limits
package dnn_pkg;

    localparam int DNN_DATA_W    = 12;
    localparam int DNN_WT_W      = 8;
    localparam int DNN_FRAC_BITS = 4;

    // Saturation limits for the default result width
    localparam int DNN_SAT_MAX = (1 << (DNN_DATA_W - 1)) - 1;
    localparam int DNN_SAT_MIN = -(1 << (DNN_DATA_W - 1));

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCALE,
        DONE
    } neuron_state_t;

    // Saturation limits for an arbitrary signed width
    function automatic int sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/neuron_scale_sat.sv
// rtl/neuron_scale_sat.sv - accumulator rescale (floor, or round-half-up under NEURON_ROUND_EN) and saturate
module neuron_scale_sat
    import dnn_pkg::*;
#(
    parameter int ACC_W     = 24,
    parameter int DATA_W    = DNN_DATA_W,
    parameter int FRAC_BITS = DNN_FRAC_BITS
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] result
);

    localparam logic signed [ACC_W:0] MAX_V = (ACC_W + 1)'(sat_max(DATA_W));
    localparam logic signed [ACC_W:0] MIN_V = (ACC_W + 1)'(sat_min(DATA_W));
`ifdef NEURON_ROUND_EN
    localparam logic signed [ACC_W:0] HALF_V = (ACC_W + 1)'(1 << (FRAC_BITS - 1));
`endif

    logic signed [ACC_W:0] acc_ext;
    logic signed [ACC_W:0] shifted;

    // One extra bit keeps the rounding add overflow-free; the shift floors toward -inf
    always_comb begin
        acc_ext = {acc[ACC_W-1], acc};
`ifdef NEURON_ROUND_EN
        acc_ext = acc_ext + HALF_V;
`endif
        shifted = acc_ext >>> FRAC_BITS;
        if (shifted > MAX_V) begin
            result = MAX_V[DATA_W-1:0];
        end else if (shifted < MIN_V) begin
            result = MIN_V[DATA_W-1:0];
        end else begin
            result = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - serial multiply-accumulate neuron with bias, rescale and saturation (NEURON_ROUND_EN selects rounding)
module neuron_mac
    import dnn_pkg::*;
#(
    parameter int NUM_IN    = 4,
    parameter int DATA_W    = DNN_DATA_W,
    parameter int WT_W      = DNN_WT_W,
    parameter int FRAC_BITS = DNN_FRAC_BITS,
    parameter int ACC_W     = 24,
    localparam int IDX_W    = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] bias,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic                     wt_wr_en,
    input  logic [IDX_W-1:0]         wt_wr_addr,
    input  logic signed [WT_W-1:0]   wt_wr_data,
    output logic signed [DATA_W-1:0] out,
    output logic                     output_ready,
    output logic                     busy
);

    localparam int PROD_W = DATA_W + WT_W;

    neuron_state_t state;
    neuron_state_t state_nxt;

    logic signed [ACC_W-1:0]  acc;
    logic [IDX_W-1:0]         idx;
    logic signed [WT_W-1:0]   w [NUM_IN];
    logic signed [PROD_W-1:0] prod;
    logic signed [DATA_W-1:0] scaled;
    logic                     start_ok;
    logic                     beat;
    logic                     last_beat;

    // Handshake decodes come from the state register only, never from x_valid
    assign x_ready   = (state == ACCUM);
    assign busy      = (state == ACCUM) || (state == SCALE);
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign beat      = x_valid && x_ready;
    assign last_beat = beat && (idx == IDX_W'(NUM_IN - 1));
    assign prod      = x_in * w[idx];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is ignored while an evaluation is in flight
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = ACCUM;
            ACCUM:      if (last_beat) state_nxt = SCALE;
            SCALE:      state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Accumulator, beat index and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc          <= '0;
            idx          <= '0;
            out          <= '0;
            output_ready <= 1'b0;
        end else if (start_ok) begin
            acc          <= {{(ACC_W - DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC_BITS;
            idx          <= '0;
            output_ready <= 1'b0;
        end else if (beat) begin
            acc <= acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
            idx <= last_beat ? '0 : idx + IDX_W'(1);
        end else if (state == SCALE) begin
            out          <= scaled;
            output_ready <= 1'b1;
        end
    end

    // Weight registers; a write lands after the edge, so a same-cycle read sees the old value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_IN; i++) begin
                w[i] <= '0;
            end
        end else if (wt_wr_en) begin
            w[wt_wr_addr] <= wt_wr_data;
        end
    end

    neuron_scale_sat #(
        .ACC_W     (ACC_W),
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_scale_sat (
        .acc    (acc),
        .result (scaled)
    );

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - table-driven scoreboard bench for neuron_mac
module tb_neuron_mac;

`ifdef NEURON_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    typedef struct {
        string name;
        int    w[4];
        int    bias;
        int    x[4];
        int    exp_t;
        int    exp_r;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic signed [11:0] bias;
    logic signed [11:0] x_in;
    logic               x_valid;
    logic               x_ready;
    logic               wt_wr_en;
    logic [1:0]         wt_wr_addr;
    logic signed [7:0]  wt_wr_data;
    logic signed [11:0] out;
    logic               output_ready;
    logic               busy;

    int total = 0;
    int bad   = 0;
    int beats = 0;
    int prev_out = 0;
    int sb[$];
    vec_t vecs[8];
    vec_t hv;

    neuron_mac dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bias         (bias),
        .x_in         (x_in),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .wt_wr_en     (wt_wr_en),
        .wt_wr_addr   (wt_wr_addr),
        .wt_wr_data   (wt_wr_data),
        .out          (out),
        .output_ready (output_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && x_valid && x_ready) beats <= beats + 1;
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic load_w(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wt_wr_en   = 1'b1;
            wt_wr_addr = 2'(i);
            wt_wr_data = 8'(v.w[i]);
        end
        @(negedge clk);
        wt_wr_en = 1'b0;
    endtask

    // Called at a negedge; drives start there and returns at the negedge where output_ready is seen
    task automatic run_eval(input vec_t v, input logic [15:0] pat, input bit glitch,
                            input int wr_cyc, input int exp_lat);
        int  k, p, cyc, b0, got, e;
        bit  vn, done;
        sb.push_back(ROUND ? v.exp_r : v.exp_t);
        start   = 1'b1;
        bias    = 12'(v.bias);
        x_valid = 1'b0;
        x_in    = '0;
        b0 = beats; k = 0; p = 0; done = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk({v.name, " ready_low"}, int'(output_ready), 0);
        chk({v.name, " busy"}, int'(busy), 1);
        chk({v.name, " out_held"}, int'($signed(out)), prev_out);
        while (!done && cyc < 64) begin
            if (output_ready) begin
                done = 1'b1;
            end else begin
                vn = (k < 4) ? pat[p] : 1'b1;
                if (p < 15) p++;
                start      = glitch && (cyc == 2);
                bias       = glitch ? 12'sd999 : bias;
                wt_wr_en   = (cyc == wr_cyc);
                wt_wr_addr = 2'd0;
                wt_wr_data = -8'sd16;
                x_valid    = vn;
                x_in       = (k < 4) ? 12'(v.x[k]) : 12'sd777;
                if (vn && x_ready) k++;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0; wt_wr_en = 1'b0; x_valid = 1'b0;
        chk({v.name, " completed"}, int'(done), 1);
        chk({v.name, " latency"}, cyc, exp_lat);
        chk({v.name, " beats"}, beats - b0, 4);
        got = int'($signed(out));
        e = sb.pop_front();
        chk({v.name, " out"}, got, e);
        prev_out = got;
    endtask

    initial begin
        vecs[0] = '{"ident",    '{16, 16, 16, 16},     0,     '{100, 200, 300, 400},   1000,  1000};
        vecs[1] = '{"neg_bias", '{-16, -16, -16, -16}, 50,    '{100, 200, 300, 400},   -950,  -950};
        vecs[2] = '{"sat_pos",  '{127, 127, 127, 127}, 0,     '{2047, 2047, 2047, 2047}, 2047, 2047};
        vecs[3] = '{"sat_neg",  '{-128, -128, -128, -128}, 0, '{2047, 2047, 2047, 2047}, -2048, -2048};
        vecs[4] = '{"rnd_pos",  '{1, 0, 0, 0},         0,     '{8, 0, 0, 0},           0,     1};
        vecs[5] = '{"rnd_neg",  '{-1, 0, 0, 0},        0,     '{8, 0, 0, 0},           -1,    0};
        vecs[6] = '{"mixed",    '{3, -5, 20, -7},      -3,    '{-100, 37, 5, -2000},   847,   848};
        vecs[7] = '{"bias_min", '{0, 0, 0, 0},         -2048, '{1, 2, 3, 4},           -2048, -2048};

        rst_n = 1'b0; start = 1'b0; bias = '0; x_in = '0; x_valid = 1'b0;
        wt_wr_en = 1'b0; wt_wr_addr = '0; wt_wr_data = '0;
        repeat (3) @(negedge clk);
        chk("reset out", int'($signed(out)), 0);
        chk("reset output_ready", int'(output_ready), 0);
        chk("reset x_ready", int'(x_ready), 0);
        chk("reset busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            load_w(vecs[i]);
            run_eval(vecs[i], 16'hFFFF, 1'b0, -1, 6);
        end

        // Stalled input with a start pulse mid-ACCUM: same result, three extra cycles
        load_w(vecs[6]);
        hv = vecs[6];
        hv.name = "stall";
        run_eval(hv, 16'hFFD9, 1'b1, -1, 9);

        // Write to index 0 on its own accept edge: old weight used now, new one next time
        load_w(vecs[0]);
        hv = vecs[0];
        hv.name = "wr_same_cycle";
        run_eval(hv, 16'hFFFF, 1'b0, 1, 6);
        hv.name = "wr_next_eval";
        hv.w = '{-16, 16, 16, 16};
        hv.exp_t = 800;
        hv.exp_r = 800;
        run_eval(hv, 16'hFFFF, 1'b0, -1, 6);

        // Reset in the middle of ACCUM, then a fresh evaluation sees cleared weights
        start = 1'b1;
        bias = 12'sd5;
        @(negedge clk);
        start = 1'b0;
        x_valid = 1'b1;
        x_in = 12'sd50;
        repeat (2) @(negedge clk);
        x_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset out", int'($signed(out)), 0);
        chk("midreset output_ready", int'(output_ready), 0);
        chk("midreset x_ready", int'(x_ready), 0);
        chk("midreset busy", int'(busy), 0);
        rst_n = 1'b1;
        prev_out = 0;
        @(negedge clk);
        hv = '{"after_reset", '{0, 0, 0, 0}, 123, '{9, 9, 9, 9}, 123, 123};
        run_eval(hv, 16'hFFFF, 1'b0, -1, 6);

        chk("scoreboard empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
